// File: rtl/operand_debouncer.sv
// Switch conditioner: 2-flop synchroniser plus whole-vector debounce of the eight
// slide switches, committing operands A/B with a one-cycle update pulse.
module operand_debouncer #(
  parameter int STABLE_TICKS = 4,
  parameter int CNT_W        = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       sample_tick,
  input  logic [7:0] sw_raw,
  output logic [3:0] A,
  output logic [3:0] B,
  output logic       valid,
  output logic       update
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_TICKS - 1);

  logic [1:0][7:0]  sync_pipe;
  logic [7:0]       sync;
  logic [7:0]       cand;
  logic [7:0]       stable;
  logic [CNT_W-1:0] cnt;

  assign sync = sync_pipe[1];

  // Synchroniser runs every clock so the tick rate never stretches metastability settling.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) sync_pipe <= '0;
    else        sync_pipe <= {sync_pipe[0], sw_raw};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cand   <= '0;
      cnt    <= '0;
      stable <= '0;
      valid  <= 1'b0;
      update <= 1'b0;
    end else begin
      update <= 1'b0;
      if (sample_tick) begin
        if (sync != cand) begin
          cand <= sync;
          cnt  <= '0;
        end else if (cnt == LAST) begin
          // Counter saturates here; steady input keeps re-committing the same value.
          stable <= cand;
          valid  <= 1'b1;
          update <= (cand != stable) || !valid;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end
    end
  end

  assign A = stable[3:0];
  assign B = stable[7:4];

endmodule

// File: tb/tb_operand_debouncer.sv
// Directed bench for operand_debouncer (STABLE_TICKS=4, tick every 4 clocks unless held).
module tb_operand_debouncer;
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       sample_tick = 1'b0;
  logic [7:0] sw_raw = 8'h00;
  logic [3:0] A, B;
  logic       valid, update;

  int   tests = 0;
  int   fails = 0;
  int   tot_upd = 0;
  logic last_upd = 1'b0;

  operand_debouncer #(.STABLE_TICKS(4), .CNT_W(8)) dut (
    .clock(clock), .reset(reset), .sample_tick(sample_tick), .sw_raw(sw_raw),
    .A(A), .B(B), .valid(valid), .update(update)
  );

  always #5 clock = ~clock;

  // Counts every cycle update was high, so a stretched pulse shows up as an extra count.
  always @(posedge clock) if (update) tot_upd <= tot_upd + 1;

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // One tick on the next posedge, then three quiet clocks; update sampled right after the tick edge.
  task automatic tick();
    sample_tick = 1'b1;
    @(negedge clock);
    last_upd = update;
    sample_tick = 1'b0;
    idle(3);
  endtask

  task automatic set_sw(input logic [7:0] v);
    sw_raw = v;
    idle(2);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %04h expected %04h", tag, obs, exp);
    end
  endtask

  // Packed view {B, A, valid, update-after-tick} for compact expectations.
  function automatic logic [15:0] st(input logic u);
    return {B, A, 3'b000, valid, 3'b000, u};
  endfunction

  initial begin
    // 1: reset with 0xA5 on the switches, then first commit
    sw_raw = 8'hA5;
    idle(3);
    chk("reset_hold", st(update), 16'h0000);
    reset = 1'b1;
    idle(2);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("s1_wait", st(last_upd), 16'h0000);
    end
    tick();
    chk("s1_commit", st(last_upd), 16'hA511);
    chk("s1_upd_cnt", 16'(tot_upd), 16'd1);

    // 2: change to 0x3C
    set_sw(8'h3C);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("s2_hold", st(last_upd), 16'hA510);
    end
    tick();
    chk("s2_commit", st(last_upd), 16'h3C11);
    chk("s2_upd_cnt", 16'(tot_upd), 16'd2);

    // 3: bounce 0x3C/0x3D on alternate ticks, then settle at 0x3D
    for (int i = 0; i < 10; i++) begin
      set_sw((i % 2 == 0) ? 8'h3D : 8'h3C);
      tick();
      chk("s3_bounce", st(last_upd), 16'h3C10);
    end
    set_sw(8'h3D);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("s3_settle", st(last_upd), 16'h3C10);
    end
    tick();
    chk("s3_commit", st(last_upd), 16'h3D11);
    chk("s3_upd_cnt", 16'(tot_upd), 16'd3);

    // 4a: one-clock glitch entirely between ticks
    sw_raw = 8'hFF;
    idle(1);
    sw_raw = 8'h3D;
    idle(3);
    tick();
    chk("s4_between", st(last_upd), 16'h3D10);
    // 4b: glitch whose synchronised copy lands on a tick
    sw_raw = 8'hFF;
    idle(1);
    sw_raw = 8'h3D;
    idle(1);
    tick();
    chk("s4_span", st(last_upd), 16'h3D10);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("s4_recommit", st(last_upd), 16'h3D10);
    end
    chk("s4_upd_cnt", 16'(tot_upd), 16'd3);

    // 5: reset two ticks into a change to 0x77
    set_sw(8'h77);
    tick();
    tick();
    chk("s5_midcount", st(last_upd), 16'h3D10);
    #2 reset = 1'b0;
    #1 chk("s5_async_rst", st(update), 16'h0000);
    @(negedge clock);
    idle(2);
    reset = 1'b1;
    idle(2);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("s5_wait", st(last_upd), 16'h0000);
    end
    tick();
    chk("s5_commit", st(last_upd), 16'h7711);
    chk("s5_upd_cnt", 16'(tot_upd), 16'd4);

    // 5b: first commit after reset with switches at 0x00 still pulses update
    reset = 1'b0;
    sw_raw = 8'h00;
    idle(2);
    reset = 1'b1;
    idle(2);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("s5b_wait", st(last_upd), 16'h0000);
    end
    tick();
    chk("s5b_zero_commit", st(last_upd), 16'h0011);
    chk("s5b_upd_cnt", 16'(tot_upd), 16'd5);

    // 6: tick held high; 0x12 loads on the 3rd edge and commits on the 7th
    sample_tick = 1'b1;
    sw_raw = 8'h12;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      chk("s6_wait", st(update), 16'h0010);
    end
    @(negedge clock);
    chk("s6_commit", st(update), 16'h1211);
    @(negedge clock);
    chk("s6_pulse_end", st(update), 16'h1210);
    idle(5);
    chk("s6_steady", st(update), 16'h1210);
    sample_tick = 1'b0;
    idle(1);
    chk("s6_upd_cnt", 16'(tot_upd), 16'd6);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
